data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: wait states inserted before each access completes (legal range 0..15).
REQ-002 Parameter DEPTH_WORDS, default 256: number of 16-bit words in the backing store (power of 2).
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 memRead  input  1  load request from the pipeline control path.
REQ-006 memWrite  input  1  store request from the pipeline control path.
REQ-007 loadByte  input  1  qualifies memRead as a byte load (lbu); 0 means a word load.
REQ-008 sByte  input  1  qualifies memWrite as a byte store (sb); 0 means a word store.
REQ-009 addr  input  16  byte address.
REQ-010 wdata  input  16  store data; a byte store uses wdata[7:0].
REQ-011 rdata  output  16  load result, valid only while valid=1.
REQ-012 valid  output  1  one-cycle completion pulse for the current access.
REQ-013 busy  output  1  stall request to the pipeline.
REQ-014 err  output  1  one-cycle pulse: access rejected.

Function
REQ-015 FSM states: IDLE, WAIT, DONE; a request is accepted only in IDLE.
REQ-016 IDLE: if exactly one of memRead/memWrite is 1 -> latch addr, wdata, loadByte, sByte and the direction; go to WAIT when WAIT_CYCLES>0, else DONE.
REQ-017 busy = 1 combinationally in the IDLE cycle that accepts a request, and registered 1 in every WAIT cycle; busy = 0 in DONE.
REQ-018 WAIT: a 4-bit counter loads WAIT_CYCLES-1 on entry and decrements each cycle; at count 0 the FSM goes to DONE.
REQ-019 DONE: perform the write or drive rdata; valid = 1 for this cycle only; next state IDLE.
REQ-020 Latency: a request accepted in cycle N produces valid in cycle N+WAIT_CYCLES+1.
REQ-021 Byte order is big-endian: addr[0]=0 selects word[15:8] and addr[0]=1 selects word[7:0].
REQ-022 Word index is addr[log2(DEPTH_WORDS):1]; upper address bits are ignored, so accesses wrap modulo the store size.
REQ-023 Byte load: rdata = {8'h00, selected byte} (zero-extended).
REQ-024 Byte store: modifies only the selected byte; the other byte is unchanged.
REQ-025 Word access with addr[0]=1 (misaligned): no write; rdata = 0; err = 1 and valid = 1 in DONE.
REQ-026 memRead and memWrite both 1 in IDLE: the request is not accepted; err = 1 in the next cycle; FSM stays in IDLE; storage is unchanged.
REQ-027 Request inputs are ignored in WAIT and DONE; a request held high through DONE is accepted again in the following IDLE cycle.
REQ-028 rdata = 0 whenever valid = 0.

Reset
REQ-029 rst=1 -> state IDLE, counter 0, busy=0, valid=0, err=0, rdata=0 on the next edge.
REQ-030 Reset during WAIT or DONE aborts the access; any pending write is not committed.
REQ-031 Storage contents are not cleared by reset.

Structure
REQ-032 A shared package holds the FSM state typedef (IDLE/WAIT/DONE) and the byte-lane constants (HI_LANE=0, LO_LANE=1).
REQ-033 The storage array is a sub-module, dmem_array: synchronous write with a 2-bit byte enable and combinational read.

Verification
REQ-034 Word store 16'hBEEF to addr 16'h0010, then word load from 16'h0010 -> valid with rdata=16'hBEEF, 3 cycles after acceptance (WAIT_CYCLES=2).
REQ-035 Byte store 16'h0012 to addr 16'h0011 over 16'hBEEF, then word load from 16'h0010 -> rdata=16'hBE12; lbu from 16'h0010 -> rdata=16'h00BE.
REQ-036 Word load from addr 16'h0021 -> err=1 and valid=1 in DONE, rdata=0; a subsequent word load from 16'h0020 is unchanged.
REQ-037 memRead=memWrite=1 in IDLE -> err pulse in the next cycle, busy stays 0, no storage change.
REQ-038 Assert rst in the WAIT cycle of a word store of 16'h1234 to addr 16'h0040 -> no valid; a later load from 16'h0040 returns the prior contents.
REQ-039 WAIT_CYCLES=0: request in cycle N -> valid in N+1; back-to-back held requests complete every 2 cycles.

Source files
------------

// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and constants for the data memory controller.
package data_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Big-endian lanes: even byte address is the high half of the word.
    localparam logic HI_LANE = 1'b0;
    localparam logic LO_LANE = 1'b1;

    function automatic logic [7:0] lane_sel(input logic [15:0] word, input logic lane);
        return (lane == HI_LANE) ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Pipeline <-> data memory controller request/response bundle.
interface data_mem_ctrl_if;
    logic        memRead;
    logic        memWrite;
    logic        loadByte;
    logic        sByte;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        valid;
    logic        busy;
    logic        err;

    modport master (
        output memRead, memWrite, loadByte, sByte, addr, wdata,
        input  rdata, valid, busy, err
    );

    modport slave (
        input  memRead, memWrite, loadByte, sByte, addr, wdata,
        output rdata, valid, busy, err
    );
endinterface

// File: rtl/dmem_array.sv
// Word-wide backing store: byte-enabled synchronous write, combinational read.
module dmem_array #(
    parameter int DEPTH_WORDS = 256,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [1:0]    be_i,
    input  logic [AW-1:0] idx_i,
    input  logic [15:0]   wdata_i,
    output logic [15:0]   rdata_o
);

    logic [15:0] mem_q [DEPTH_WORDS];

    // Write enabled lanes; contents are deliberately never reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            if (be_i[1]) mem_q[idx_i][15:8] <= wdata_i[15:8];
            if (be_i[0]) mem_q[idx_i][7:0]  <= wdata_i[7:0];
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: single outstanding access with fixed wait states,
// big-endian byte lanes, misaligned-word and conflicting-request rejection.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH_WORDS = 256
) (
    input logic            clk,
    input logic            rst,
    data_mem_ctrl_if.slave bus
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [15:0] addr_q, wdata_q;
    logic        byte_q, wr_q;

    logic        req_one, req_both, accept, misalign;
    logic        busy_w, valid_w, err_w, we_w;
    logic [1:0]  be_w;
    logic [15:0] rdata_w, word_rd, mem_wdata;
    logic [AW-1:0] idx;
    logic        unused_addr;

    assign req_one   = bus.memRead ^ bus.memWrite;
    assign req_both  = bus.memRead & bus.memWrite;
    assign accept    = (state_q == IDLE) && req_one;
    assign misalign  = !byte_q && addr_q[0];
    assign idx       = addr_q[AW:1];
    assign mem_wdata = byte_q ? {wdata_q[7:0], wdata_q[7:0]} : wdata_q;
    // Upper address bits fall outside the store and wrap by design.
    assign unused_addr = ^addr_q[15:AW+1];

    // State, wait counter, conflict flag and request latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            addr_q  <= 16'd0;
            wdata_q <= 16'd0;
            byte_q  <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (accept) begin
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
                byte_q  <= bus.memRead ? bus.loadByte : bus.sByte;
                wr_q    <= bus.memWrite;
            end
        end
    end

    // Next-state and counter sequencing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d = DONE;
                    end
                end else if (req_both) begin
                    err_d = 1'b1;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = DONE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs, write strobe and load data formatting.
    always_comb begin
        busy_w  = 1'b0;
        valid_w = 1'b0;
        err_w   = err_q;
        rdata_w = 16'd0;
        we_w    = 1'b0;
        be_w    = 2'b00;
        case (state_q)
            IDLE: busy_w = accept;
            WAIT: busy_w = 1'b1;
            DONE: begin
                valid_w = 1'b1;
                if (misalign) begin
                    err_w = 1'b1;
                end else if (wr_q) begin
                    // A reset landing on the DONE edge must not commit the write.
                    we_w = !rst;
                    if (byte_q) be_w = (addr_q[0] == HI_LANE) ? 2'b10 : 2'b01;
                    else        be_w = 2'b11;
                end else begin
                    rdata_w = byte_q ? {8'h00, lane_sel(word_rd, addr_q[0])} : word_rd;
                end
            end
            default: ;
        endcase
    end

    assign bus.busy  = busy_w;
    assign bus.valid = valid_w;
    assign bus.err   = err_w;
    assign bus.rdata = rdata_w;

    dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk_i   (clk),
        .we_i    (we_w),
        .be_i    (be_w),
        .idx_i   (idx),
        .wdata_i (mem_wdata),
        .rdata_o (word_rd)
    );

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed scoreboard bench for data_mem_ctrl (WAIT_CYCLES=2 and 0 instances).
module tb_data_mem_ctrl;

    typedef struct {
        int          exp_cyc;
        logic [15:0] rdata;
        logic        err;
        bit          chk_rd;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;
    exp_t sb2[$];
    exp_t sb0[$];
    logic [15:0] model [256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_ctrl_if bus2 ();
    data_mem_ctrl_if bus0 ();

    data_mem_ctrl #(.WAIT_CYCLES(2), .DEPTH_WORDS(256)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    data_mem_ctrl #(.WAIT_CYCLES(0), .DEPTH_WORDS(256)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard for the WAIT_CYCLES=2 instance.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus2.valid) begin
                if (sb2.size() == 0) begin
                    chk("unexpected_valid2", 32'd1, 32'd0);
                end else begin
                    e = sb2.pop_front();
                    chk("latency2", cyc, e.exp_cyc);
                    chk("err2", {31'd0, bus2.err}, {31'd0, e.err});
                    chk("busy_done2", {31'd0, bus2.busy}, 32'd0);
                    if (e.chk_rd) chk("rdata2", {16'd0, bus2.rdata}, {16'd0, e.rdata});
                end
            end else begin
                chk("rdata_idle2", {16'd0, bus2.rdata}, 32'd0);
            end
        end
    end

    // Scoreboard for the WAIT_CYCLES=0 instance.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus0.valid) begin
            if (sb0.size() == 0) begin
                chk("unexpected_valid0", 32'd1, 32'd0);
            end else begin
                e = sb0.pop_front();
                chk("latency0", cyc, e.exp_cyc);
                chk("err0", {31'd0, bus0.err}, {31'd0, e.err});
                if (e.chk_rd) chk("rdata0", {16'd0, bus0.rdata}, {16'd0, e.rdata});
            end
        end
    end

    task automatic clear2();
        bus2.memRead = 1'b0; bus2.memWrite = 1'b0; bus2.loadByte = 1'b0;
        bus2.sByte = 1'b0; bus2.addr = 16'd0; bus2.wdata = 16'd0;
    endtask

    task automatic clear0();
        bus0.memRead = 1'b0; bus0.memWrite = 1'b0; bus0.loadByte = 1'b0;
        bus0.sByte = 1'b0; bus0.addr = 16'd0; bus0.wdata = 16'd0;
    endtask

    task automatic drain2();
        for (int i = 0; i < 20 && sb2.size() != 0; i++) @(posedge clk);
        chk("drain2", sb2.size(), 32'd0);
        sb2.delete();
    endtask

    // One access on the WAIT_CYCLES=2 instance, expectations from the model.
    task automatic access2(input bit wr, input bit bt, input logic [15:0] a, input logic [15:0] wd);
        exp_t e;
        logic [7:0] ix;
        logic mis;
        ix  = a[8:1];
        mis = !bt && a[0];
        e.err = mis;
        e.rdata = 16'd0;
        e.chk_rd = 1'b1;
        if (!mis) begin
            if (wr) begin
                e.chk_rd = 1'b0;
                if (!bt)       model[ix] = wd;
                else if (!a[0]) model[ix][15:8] = wd[7:0];
                else           model[ix][7:0]  = wd[7:0];
            end else begin
                e.rdata = !bt ? model[ix] : (!a[0] ? {8'h00, model[ix][15:8]} : {8'h00, model[ix][7:0]});
            end
        end
        @(posedge clk); #1;
        bus2.memRead = !wr; bus2.memWrite = wr; bus2.loadByte = bt; bus2.sByte = bt;
        bus2.addr = a; bus2.wdata = wd;
        e.exp_cyc = cyc + 3;
        sb2.push_back(e);
        #1 chk("busy_accept2", {31'd0, bus2.busy}, 32'd1);
        @(posedge clk); #1;
        clear2();
        chk("busy_wait2", {31'd0, bus2.busy}, 32'd1);
        drain2();
    endtask

    initial begin
        exp_t e;
        int c;
        rst = 1'b1;
        clear2();
        clear0();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid2", {31'd0, bus2.valid}, 32'd0);
        chk("rst_err2",   {31'd0, bus2.err},   32'd0);
        chk("rst_busy2",  {31'd0, bus2.busy},  32'd0);
        chk("rst_rdata2", {16'd0, bus2.rdata}, 32'd0);
        chk("rst_valid0", {31'd0, bus0.valid}, 32'd0);
        rst = 1'b0;

        access2(1'b1, 1'b0, 16'h0010, 16'hBEEF);
        access2(1'b0, 1'b0, 16'h0010, 16'h0000);
        access2(1'b1, 1'b1, 16'h0011, 16'h0012);
        access2(1'b0, 1'b0, 16'h0010, 16'h0000);
        access2(1'b0, 1'b1, 16'h0010, 16'h0000);
        access2(1'b0, 1'b1, 16'h0011, 16'h0000);
        access2(1'b1, 1'b1, 16'h0020, 16'h00CA);
        access2(1'b1, 1'b1, 16'h0021, 16'hFFFE);
        access2(1'b0, 1'b0, 16'h0021, 16'h0000);
        access2(1'b1, 1'b0, 16'h0021, 16'h1111);
        access2(1'b0, 1'b0, 16'h0020, 16'h0000);
        access2(1'b1, 1'b0, 16'h0210, 16'h7777);
        access2(1'b0, 1'b0, 16'h0010, 16'h0000);

        // Conflicting request: rejected, error pulse next cycle, storage untouched.
        @(posedge clk); #1;
        bus2.memRead = 1'b1; bus2.memWrite = 1'b1; bus2.addr = 16'h0010; bus2.wdata = 16'hDEAD;
        #1 chk("both_busy", {31'd0, bus2.busy}, 32'd0);
        @(posedge clk); #1;
        chk("both_err",   {31'd0, bus2.err},   32'd1);
        chk("both_valid", {31'd0, bus2.valid}, 32'd0);
        chk("both_busy2", {31'd0, bus2.busy},  32'd0);
        clear2();
        @(posedge clk); #1;
        chk("both_err_clr", {31'd0, bus2.err}, 32'd0);
        access2(1'b0, 1'b0, 16'h0010, 16'h0000);

        // Reset during WAIT aborts the store.
        access2(1'b1, 1'b0, 16'h0040, 16'hA5A5);
        @(posedge clk); #1;
        bus2.memWrite = 1'b1; bus2.addr = 16'h0040; bus2.wdata = 16'h1234;
        @(posedge clk); #1;
        clear2();
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_valid", {31'd0, bus2.valid}, 32'd0);
        chk("abort_busy",  {31'd0, bus2.busy},  32'd0);
        chk("abort_err",   {31'd0, bus2.err},   32'd0);
        chk("abort_rdata", {16'd0, bus2.rdata}, 32'd0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        access2(1'b0, 1'b0, 16'h0040, 16'h0000);

        // Zero wait states: single store, then held loads every other cycle.
        @(posedge clk); #1;
        bus0.memWrite = 1'b1; bus0.addr = 16'h0002; bus0.wdata = 16'h5A5A;
        e.exp_cyc = cyc + 1; e.rdata = 16'd0; e.err = 1'b0; e.chk_rd = 1'b0;
        sb0.push_back(e);
        #1 chk("busy_accept0", {31'd0, bus0.busy}, 32'd1);
        @(posedge clk); #1;
        clear0();
        chk("busy_done0", {31'd0, bus0.busy}, 32'd0);
        @(posedge clk); #1;
        bus0.memRead = 1'b1; bus0.addr = 16'h0002;
        c = cyc;
        for (int k = 0; k < 3; k++) begin
            e.exp_cyc = c + 1 + 2 * k; e.rdata = 16'h5A5A; e.err = 1'b0; e.chk_rd = 1'b1;
            sb0.push_back(e);
        end
        repeat (6) @(posedge clk);
        #1 clear0();
        for (int i = 0; i < 20 && sb0.size() != 0; i++) @(posedge clk);
        chk("drain0", sb0.size(), 32'd0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
